// File: rtl/i2c_target_regs.sv
// I2C target with a small register bank: oversampled SCL/SDA, open-drain SDA,
// auto-incrementing register pointer, local read port and per-byte write strobe.
module i2c_target_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS   = 16,
  localparam int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          i2c_scl,
  inout  wire           i2c_sda,
  input  logic [AW-1:0] reg_rd_addr,
  output logic [7:0]    reg_rd_data,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRack, StIgnore
  } state_e;

  state_e state_q, state_d;

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]    cnt_q, cnt_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [6:0]    tx_q, tx_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          reg_we;
  logic [7:0]    byte_in, rd_byte;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic          wr_strobe_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q, rd_data_q;

  // Synchronizers reset high so reset release never looks like a START.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= i2c_scl;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= i2c_sda;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

  assign byte_in = {shreg_q, sda_sync_q};
  assign rd_byte = regs_q[ptr_q];

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // In ACK states cnt_q flags that the 9th rise has been seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    reg_we  = 1'b0;
    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shreg_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              case (state_q)
                StAddr: begin
                  rw_d    = byte_in[0];
                  state_d = (byte_in[7:1] == SLAVE_ADDR) ? StAddrAck : StIgnore;
                end
                StPtr: begin
                  ptr_d   = byte_in[AW-1:0];
                  state_d = StPtrAck;
                end
                default: begin
                  reg_we  = 1'b1;
                  ptr_d   = ptr_q + 1'b1;
                  state_d = StWdataAck;
                end
              endcase
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_rise) begin
            cnt_d = 4'd1;
          end else if (scl_fall && cnt_q != 4'd0) begin
            cnt_d = 4'd0;
            if (state_q == StAddrAck && rw_q) begin
              tx_d    = rd_byte[6:0];
              state_d = StRdata;
            end else begin
              state_d = (state_q == StAddrAck) ? StPtr : StWdata;
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d   = 4'd0;
              state_d = StRack;
            end else begin
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            ptr_d = ptr_q + 1'b1;
            if (sda_sync_q) state_d = StIgnore;
            else            cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q != 4'd0) begin
            cnt_d   = 4'd0;
            tx_d    = rd_byte[6:0];
            state_d = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  // SDA drive only ever changes on a synced SCL fall (or bus condition).
  always_comb begin
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (scl_fall) begin
      case (state_q)
        StAddrAck:            sda_oe_d = (cnt_q == 4'd0) | (rw_q & ~rd_byte[7]);
        StPtrAck, StWdataAck: sda_oe_d = (cnt_q == 4'd0);
        StRdata:              sda_oe_d = (cnt_q != 4'd8) & ~tx_q[6];
        StRack:               sda_oe_d = (cnt_q != 4'd0) & ~rd_byte[7];
        default:              sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt_q       <= 4'd0;
      shreg_q     <= 7'd0;
      tx_q        <= 7'd0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      rd_data_q   <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= reg_we;
      if (reg_we) begin
        regs_q[ptr_q] <= byte_in;
        wr_addr_q     <= ptr_q;
        wr_data_q     <= byte_in;
      end
      rd_data_q <= regs_q[reg_rd_addr];
    end
  end

  assign i2c_sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_rd_data = rd_data_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master on a pulled-up SDA wire,
// table of write transactions plus hand-written read, mismatch and reset sequences.
module tb_i2c_target_regs;

  logic       PCLK      = 1'b0;
  logic       PRESETn   = 1'b0;
  logic       scl_m     = 1'b1;
  logic       sda_m_low = 1'b0;
  logic [3:0] rd_addr   = 4'd0;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda;

  assign sda = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 PCLK = ~PCLK;

  i2c_target_regs #(
    .SLAVE_ADDR(7'h50),
    .NUM_REGS  (16)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .i2c_scl    (scl_m),
    .i2c_sda    (sda),
    .reg_rd_addr(rd_addr),
    .reg_rd_data(rd_data),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Strobe log and count of cycles where the target pulls SDA low.
  logic [11:0] strb_log [64];
  int          strb_n    = 0;
  int          tgt_low_n = 0;

  always @(negedge PCLK) begin
    if (wr_strobe && strb_n < 64) begin
      strb_log[strb_n] = {wr_addr, wr_data};
      strb_n++;
    end
    if (!sda_m_low && sda === 1'b0) tgt_low_n++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] idx0;
    logic [3:0] idx1;
  } wvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic q();
    repeat (4) @(negedge PCLK);
  endtask

  task automatic i2c_start();
    sda_m_low = 1'b0; q();
    scl_m     = 1'b1; q();
    sda_m_low = 1'b1; q();
    scl_m     = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m_low = 1'b1; q();
    scl_m     = 1'b1; q();
    sda_m_low = 1'b0; q();
  endtask

  task automatic put_bit(input logic b);
    sda_m_low = ~b; q();
    scl_m     = 1'b1; q(); q();
    scl_m     = 1'b0; q();
  endtask

  task automatic get_bit(output logic b);
    sda_m_low = 1'b0; q();
    scl_m     = 1'b1; q();
    b         = sda;  q();
    scl_m     = 1'b0; q();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~mack);
  endtask

  task automatic rd_local(input logic [3:0] a, output logic [7:0] d);
    @(negedge PCLK);
    rd_addr = a;
    @(negedge PCLK);
    d = rd_data;
  endtask

  task automatic run_wvec(input wvec_t v, input string tag);
    logic       a;
    int         acks;
    int         base;
    logic [7:0] d;
    base = strb_n;
    acks = 0;
    i2c_start();
    put_byte(8'hA0, a); if (a) acks++;
    check({tag, " busy mid"}, 32'(busy), 32'd1);
    put_byte(v.ptr, a); if (a) acks++;
    put_byte(v.d0, a);  if (a) acks++;
    put_byte(v.d1, a);  if (a) acks++;
    i2c_stop();
    check({tag, " acks"}, 32'(acks), 32'd4);
    check({tag, " strobes"}, 32'(strb_n - base), 32'd2);
    check({tag, " strobe0"}, 32'(strb_log[base]), 32'({v.idx0, v.d0}));
    check({tag, " strobe1"}, 32'(strb_log[base + 1]), 32'({v.idx1, v.d1}));
    check({tag, " busy after stop"}, 32'(busy), 32'd0);
    rd_local(v.idx0, d);
    check({tag, " rd idx0"}, 32'(d), 32'(v.d0));
    rd_local(v.idx1, d);
    check({tag, " rd idx1"}, 32'(d), 32'(v.d1));
  endtask

  initial begin
    wvec_t      vecs [6];
    wvec_t      post_v;
    logic       a;
    logic       b;
    logic [7:0] d;
    int         base;
    int         low0;

    vecs[0] = '{8'h03, 8'h5A, 8'hC3, 4'd3,  4'd4};
    vecs[1] = '{8'h0F, 8'hAA, 8'hBB, 4'd15, 4'd0};
    vecs[2] = '{8'h13, 8'h77, 8'h88, 4'd3,  4'd4};
    vecs[3] = '{8'h02, 8'h11, 8'h22, 4'd2,  4'd3};
    vecs[4] = '{8'h04, 8'h33, 8'h44, 4'd4,  4'd5};
    vecs[5] = '{8'h06, 8'h0F, 8'hE1, 4'd6,  4'd7};
    post_v  = '{8'h01, 8'h5C, 8'h6D, 4'd1,  4'd2};

    // Reset values
    repeat (4) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_data", 32'(wr_data), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset sda released", 32'(sda), 32'd1);
    rd_local(4'd9, d);
    check("reset reg9", 32'(d), 32'd0);

    for (int i = 0; i < 6; i++) run_wvec(vecs[i], $sformatf("wvec%0d", i));

    // Read with repeated START from pointer 2
    base = strb_n;
    i2c_start();
    put_byte(8'hA0, a); check("rd addr ack", 32'(a), 32'd1);
    put_byte(8'h02, a); check("rd ptr ack", 32'(a), 32'd1);
    i2c_start();
    put_byte(8'hA1, a); check("rd raddr ack", 32'(a), 32'd1);
    get_byte(1'b1, d);  check("rd byte0", 32'(d), 32'h11);
    get_byte(1'b1, d);  check("rd byte1", 32'(d), 32'h22);
    get_byte(1'b0, d);  check("rd byte2", 32'(d), 32'h33);
    check("rd sda released after nack", 32'(sda), 32'd1);
    i2c_stop();
    check("rd no strobes", 32'(strb_n - base), 32'd0);
    // Pointer should now be 5
    i2c_start();
    put_byte(8'hA1, a); check("rd2 addr ack", 32'(a), 32'd1);
    get_byte(1'b0, d);  check("rd2 ptr continues", 32'(d), 32'h44);
    i2c_stop();

    // Address mismatch
    base = strb_n;
    low0 = tgt_low_n;
    i2c_start();
    put_byte(8'hA2, a); check("mis addr nack", 32'(a), 32'd0);
    check("mis busy", 32'(busy), 32'd1);
    put_byte(8'h00, a); check("mis ptr nack", 32'(a), 32'd0);
    put_byte(8'h99, a); check("mis data nack", 32'(a), 32'd0);
    i2c_stop();
    check("mis never driven", 32'(tgt_low_n - low0), 32'd0);
    check("mis no strobes", 32'(strb_n - base), 32'd0);
    rd_local(4'd0, d);
    check("mis reg0 unchanged", 32'(d), 32'hBB);
    check("mis busy after stop", 32'(busy), 32'd0);

    // Reset while the target drives a 0 bit of regs[6]=0x0F
    i2c_start();
    put_byte(8'hA0, a);
    put_byte(8'h06, a);
    i2c_start();
    put_byte(8'hA1, a); check("rst raddr ack", 32'(a), 32'd1);
    get_bit(b);         check("rst bit7", 32'(b), 32'd0);
    get_bit(b);         check("rst bit6", 32'(b), 32'd0);
    check("rst target driving 0", 32'(sda), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b0;
    @(posedge PCLK);
    #1;
    check("rst sda released", 32'(sda), 32'd1);
    @(negedge PCLK);
    scl_m     = 1'b1;
    sda_m_low = 1'b0;
    repeat (4) @(negedge PCLK);
    PRESETn = 1'b1;
    q();
    check("rst busy", 32'(busy), 32'd0);
    rd_local(4'd6, d);
    check("rst regs cleared", 32'(d), 32'd0);
    run_wvec(post_v, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Synthesizable I2C target (slave) with a small register bank. It sits on the far side of the `i2c_scl`/`i2c_sda` wires driven by the `i2c_top` APB master, consuming the transactions it produces. It serves as the on-chip loopback target for SoC bring-up and as the bench partner for master verification. All logic runs on `PCLK`; the bus pins are oversampled, and no clock stretching is performed.

## Interface
- `SLAVE_ADDR`, 7'h50, 7-bit target address; the write address byte is 0xA0 and the read address byte is 0xA1.
- `NUM_REGS`, 16, register-bank depth. Must be a power of 2, between 2 and 256. `AW = log2(NUM_REGS)`.
- `PCLK  in  1`: single clock for all logic.
- `PRESETn  in  1`: reset, synchronous and active-low.
- `i2c_scl  in  1`: bus clock, sampled only (never driven).
- `i2c_sda  inout  1`: open-drain. The block drives only 0 or Z.
- `reg_rd_addr  in  AW`: local read-port address.
- `reg_rd_data  out  8`: `regs[reg_rd_addr]`, registered with 1-cycle latency.
- `wr_strobe  out  1`: 1-cycle pulse for each data byte written over I2C.
- `wr_addr  out  AW`, `wr_data  out  8`: index and value of the last I2C write. Both are valid while `wr_strobe` is high and hold afterwards.
- `busy  out  1`: high from a detected START until the next detected STOP.

## Operation
- **Input conditioning.** SCL and SDA each pass through a 2-flop synchronizer plus a previous-value flop, which gives rise/fall detection.
- **Bus conditions.**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognized in every state.
- **Sampling and driving.** Data is sampled on synced SCL rise. SDA drive changes only on synced SCL fall.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- **Transitions:**
  - Any state → ADDR on START (this covers repeated START). The bit counter clears; `ptr` is kept.
  - Any state → IDLE on STOP. SDA is released.
  - ADDR: shift 8 bits MSB-first.
    - If `byte[7:1]==SLAVE_ADDR`, go to ADDR_ACK.
    - Otherwise go to IGNORE, with SDA never driven.
  - ADDR_ACK: drive SDA=0 from the SCL fall after bit 8 until the SCL fall after the 9th rise. Then go to PTR if R/W=0, or to RDATA if R/W=1 (loading `regs[ptr]` into the shifter).
  - PTR: after 8 bits, `ptr <= byte[AW-1:0]` (upper bits dropped). Go to PTR_ACK, then WDATA.
  - WDATA: after 8 bits, `regs[ptr] <= byte` and `wr_strobe` pulses with `wr_addr=ptr`, `wr_data=byte`. Then `ptr <= ptr+1` mod NUM_REGS. Go to WDATA_ACK (always ACK), then back to WDATA.
  - RDATA: drive the shifter MSB-first, updating on each SCL fall. The first bit is driven on the SCL fall that ends the preceding ACK. After 8 bits, release SDA and go to RACK.
  - RACK: on the 9th rise, `ptr <= ptr+1` mod NUM_REGS.
    - If the sampled SDA is 0 (ACK), load `regs[ptr+1]` and return to RDATA.
    - If it is 1 (NACK), go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Port conflicts.** If an I2C write and the local read target the same index in the same cycle, `reg_rd_data` returns the old value.

## Timing
- **Reset values:**
  - `regs` all 0, `ptr`=0, state IDLE.
  - SDA released.
  - `busy`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `reg_rd_data`=0.
  - All synchronizers at 1, so no false START on reset release.
- **Reset mid-transfer.** SDA is released on the first `PCLK` edge with `PRESETn`=0. No `wr_strobe` occurs for a partial byte.
- **Pin-to-action latency.** A pin change acts on the 3rd `PCLK` edge after it. SDA drive is therefore updated ≤3 `PCLK` after the SCL fall at the pin.
- **Clock ratio.** `PCLK` ≥ 8× SCL frequency is required.
- **Strobe timing.** `wr_strobe` is asserted 1 cycle after the synced 8th SCL rise of a data byte.
- **Local read port.** `reg_rd_data` is valid 1 cycle after `reg_rd_addr`.
- **Busy timing.** `busy` rises 1 cycle after START detection and falls 1 cycle after STOP detection. It is independent of address match.

## Test plan
- **Reset:** reset for 4 cycles, release → all outputs at reset values, SDA=Z, `busy`=0.
- **Write:** START, 0xA0, 0x03, 0x5A, 0xC3, STOP → 4 ACKs.
  - `wr_strobe` pulses with (3, 0x5A), then (4, 0xC3).
  - Local read of addresses 3 and 4 returns 0x5A and 0xC3.
  - `busy` falls after STOP.
- **Read with repeated START:** preload regs[2..4] = 0x11, 0x22, 0x33. Send START, 0xA0, 0x02, Sr, 0xA1, then read ACK, ACK, NACK, STOP.
  - Master receives 0x11, 0x22, 0x33.
  - SDA is released after the NACK.
  - `ptr`=5.
- **Wrap and truncation:**
  - Pointer 0x0F, data 0xAA, 0xBB → regs[15]=0xAA, regs[0]=0xBB.
  - Pointer byte 0x13 → writes land at index 3.
- **Address mismatch:** START, 0xA2, 0x00, 0x99, STOP → SDA never driven low, no `wr_strobe`, regs unchanged, `busy` still 1 during the transfer.
- **Reset mid-read:** assert `PRESETn`=0 while the target is driving a 0 bit → SDA=Z next edge. A subsequent full write transaction is ACKed normally.
